// File: rtl/conv_row_window_feeder_if.sv
// Pixel stream handshake into the row window feeder.
// One beat carries all D channels of a single pixel.
interface conv_row_window_feeder_if #(
    parameter int D  = 4,
    parameter int DW = 8
);
    logic [D*DW-1:0] pix_i;
    logic            pix_valid_i;
    logic            pix_ready_o;

    modport master (
        output pix_i,
        output pix_valid_i,
        input  pix_ready_o
    );

    modport slave (
        input  pix_i,
        input  pix_valid_i,
        output pix_ready_o
    );
endinterface

// File: rtl/conv_row_window_feeder.sv
// Builds zero-padded top/centre/bottom row windows from a raster stream
// and hands one window per output row to the downstream conv stage.
module conv_row_window_feeder #(
    parameter int D                = 4,
    parameter int H                = 12,
    parameter int W                = 12,
    parameter int input_DATA_WIDTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rstn_i,
    conv_row_window_feeder_if.slave              pix,
    input  logic                                 conv_done_i,
    output logic [input_DATA_WIDTH*D*(W+2)-1:0]  image0,
    output logic [input_DATA_WIDTH*D*(W+2)-1:0]  image1,
    output logic [input_DATA_WIDTH*D*(W+2)-1:0]  image2,
    output logic                                 image_start,
    output logic                                 frame_done_o,
    output logic                                 busy_o
);
    localparam int DW = input_DATA_WIDTH;
    localparam int SW = DW * (W + 2);
    localparam int RB = SW * D;
    localparam int CW = $clog2(W + 1);
    localparam int NW = $clog2(H + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
    localparam logic [NW-1:0] ROW_ALL  = NW'(H);
    localparam logic [NW-1:0] WIN_LAST = NW'(H - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        DONE
    } state_t;

    state_t        state;
    logic [RB-1:0] top;
    logic [RB-1:0] mid;
    logic [RB-1:0] bot;
    logic [RB-1:0] bot_wr;
    logic [CW-1:0] col_cnt;
    logic [NW-1:0] row_cnt;
    logic [NW-1:0] win_cnt;
    logic          ready;
    logic          accept;

    assign pix.pix_ready_o = ready;
    assign accept          = pix.pix_valid_i && ready;
    assign image0          = top;
    assign image1          = mid;
    assign image2          = bot;

    // Bottom row with the incoming beat merged in; edge slots never written.
    always_comb begin
        bot_wr = bot;
        for (int d = 0; d < D; d++) begin
            bot_wr[SW*d + DW*(int'(col_cnt) + 1) +: DW] = pix.pix_i[DW*d +: DW];
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state        <= IDLE;
            top          <= '0;
            mid          <= '0;
            bot          <= '0;
            col_cnt      <= '0;
            row_cnt      <= '0;
            win_cnt      <= '0;
            ready        <= 1'b0;
            busy_o       <= 1'b0;
            image_start  <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            image_start  <= 1'b0;
            frame_done_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    state  <= LOAD;
                    ready  <= 1'b1;
                    busy_o <= 1'b1;
                end
                LOAD: begin
                    if (accept) begin
                        bot <= bot_wr;
                        if (col_cnt == COL_LAST) begin
                            col_cnt <= '0;
                            row_cnt <= row_cnt + 1'b1;
                            // Row 0 alone cannot form a window: slide it up.
                            if (row_cnt == '0) begin
                                top <= mid;
                                mid <= bot_wr;
                                bot <= '0;
                            end else begin
                                state       <= START;
                                ready       <= 1'b0;
                                image_start <= 1'b1;
                            end
                        end else begin
                            col_cnt <= col_cnt + 1'b1;
                        end
                    end
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (conv_done_i) begin
                        win_cnt <= win_cnt + 1'b1;
                        if (win_cnt == WIN_LAST) begin
                            state        <= DONE;
                            frame_done_o <= 1'b1;
                        end else begin
                            top <= mid;
                            mid <= bot;
                            bot <= '0;
                            // All rows in: next window is the bottom padding one.
                            if (row_cnt == ROW_ALL) begin
                                state       <= START;
                                image_start <= 1'b1;
                            end else begin
                                state <= LOAD;
                                ready <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy_o  <= 1'b0;
                    top     <= '0;
                    mid     <= '0;
                    bot     <= '0;
                    col_cnt <= '0;
                    row_cnt <= '0;
                    win_cnt <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_conv_row_window_feeder.sv
// Scoreboard bench for conv_row_window_feeder: a 2ch 4x4 instance with
// randomized traffic and a 1ch 2x1 instance for the smallest frame.
module tb_conv_row_window_feeder;
    localparam int DA  = 2;
    localparam int HA  = 4;
    localparam int WA  = 4;
    localparam int DWD = 8;
    localparam int VA  = DWD * DA * (WA + 2);
    localparam int VB  = DWD * 1 * 3;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    conv_row_window_feeder_if #(.D(DA), .DW(DWD)) pa ();
    conv_row_window_feeder_if #(.D(1), .DW(DWD)) pb ();

    logic          done_a_resp = 1'b0;
    logic          done_a_spur = 1'b0;
    logic          done_b      = 1'b0;
    logic [VA-1:0] a0, a1, a2;
    logic          st_a, fd_a, busy_a;
    logic [VB-1:0] b0, b1, b2;
    logic          st_b, fd_b, busy_b;

    conv_row_window_feeder #(
        .D(DA), .H(HA), .W(WA), .input_DATA_WIDTH(DWD)
    ) dut_a (
        .clk          (clk),
        .rstn_i       (rstn),
        .pix          (pa),
        .conv_done_i  (done_a_resp | done_a_spur),
        .image0       (a0),
        .image1       (a1),
        .image2       (a2),
        .image_start  (st_a),
        .frame_done_o (fd_a),
        .busy_o       (busy_a)
    );

    conv_row_window_feeder #(
        .D(1), .H(2), .W(1), .input_DATA_WIDTH(DWD)
    ) dut_b (
        .clk          (clk),
        .rstn_i       (rstn),
        .pix          (pb),
        .conv_done_i  (done_b),
        .image0       (b0),
        .image1       (b1),
        .image2       (b2),
        .image_start  (st_b),
        .frame_done_o (fd_b),
        .busy_o       (busy_b)
    );

    task automatic check(string name, logic [VA-1:0] act, logic [VA-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference frame and window model for instance A
    logic [7:0] fa [HA][WA][DA];

    typedef struct {
        logic [VA-1:0] i0, i1, i2;
        int            acc;
    } exp_a_t;
    typedef struct {
        logic [VB-1:0] i0, i1, i2;
    } exp_b_t;

    exp_a_t qa[$];
    exp_b_t qb[$];
    exp_a_t ea;
    exp_b_t eb;

    int acc_a = 0;
    int starts_a = 0;
    int fds_a = 0;
    int last_done_cyc = 0;
    int starts_b = 0;
    int fds_b = 0;
    int delay_a = 3;
    bit spur_start = 0;
    logic [VA-1:0] log0 [64];
    logic [VA-1:0] log1 [64];
    logic [VA-1:0] log2 [64];
    logic [VA-1:0] h0, h1, h2;
    bit bad;

    function automatic logic [VA-1:0] row_vec(int r);
        logic [VA-1:0] v;
        v = '0;
        if (r >= 0 && r < HA) begin
            for (int d = 0; d < DA; d++) begin
                for (int c = 0; c < WA; c++) begin
                    v[DWD*(WA+2)*d + DWD*(c+1) +: DWD] = fa[r][c][d];
                end
            end
        end
        return v;
    endfunction

    task automatic fill_a(int kind);
        for (int r = 0; r < HA; r++)
            for (int c = 0; c < WA; c++)
                for (int d = 0; d < DA; d++)
                    fa[r][c][d] = (kind == 0) ? 8'(16*r + c + 1 + 64*d) : 8'($urandom);
    endtask

    task automatic push_a(int nwin);
        exp_a_t e;
        for (int k = 0; k < nwin; k++) begin
            e.i0  = row_vec(k - 1);
            e.i1  = row_vec(k);
            e.i2  = row_vec(k + 1);
            e.acc = acc_a + WA * ((k + 2 < HA) ? k + 2 : HA);
            qa.push_back(e);
        end
    endtask

    task automatic send_a(logic [DA*DWD-1:0] v, bit gaps, bit spur);
        int n;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        pa.pix_i       = v;
        pa.pix_valid_i = 1'b1;
        n = 0;
        while (!pa.pix_ready_o && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("a_ready_wait", pa.pix_ready_o, 1);
        acc_a++;
        if (spur) done_a_spur = 1'b1;
        @(negedge clk);
        done_a_spur    = 1'b0;
        pa.pix_valid_i = 1'b0;
    endtask

    task automatic send_rows(int npix, bit gaps, bit spur);
        logic [DA*DWD-1:0] v;
        int r, c;
        for (int p = 0; p < npix; p++) begin
            r = p / WA;
            c = p % WA;
            for (int d = 0; d < DA; d++) v[DWD*d +: DWD] = fa[r][c][d];
            send_a(v, gaps, spur && r >= 1 && c == 1);
        end
    endtask

    task automatic frame_a(int kind, bit gaps, bit spur);
        int s0, f0, n;
        s0 = starts_a;
        f0 = fds_a;
        n  = 0;
        fill_a(kind);
        push_a(HA);
        send_rows(HA * WA, gaps, spur);
        while (fds_a == f0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check("a_frame_done_count", fds_a - f0, 1);
        check("a_windows_per_frame", starts_a - s0, HA);
    endtask

    task automatic send_b(logic [7:0] v);
        int n;
        pb.pix_i       = v;
        pb.pix_valid_i = 1'b1;
        n = 0;
        while (!pb.pix_ready_o && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("b_ready_wait", pb.pix_ready_o, 1);
        @(negedge clk);
        pb.pix_valid_i = 1'b0;
    endtask

    // Monitor A: pop and compare every window, count frame_done pulses
    initial forever begin
        @(negedge clk);
        if (st_a === 1'b1) begin
            if (starts_a < 64) begin
                log0[starts_a] = a0;
                log1[starts_a] = a1;
                log2[starts_a] = a2;
            end
            starts_a++;
            if (qa.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL a_extra_window: got start #%0d want none", starts_a);
            end else begin
                ea = qa.pop_front();
                check("a_win_top", a0, ea.i0);
                check("a_win_mid", a1, ea.i1);
                check("a_win_bot", a2, ea.i2);
                check("a_accepted_at_start", acc_a, ea.acc);
            end
        end
        if (fd_a === 1'b1) begin
            fds_a++;
            check("a_fd_latency_ok", (cyc - last_done_cyc >= 1) && (cyc - last_done_cyc <= 2), 1);
        end
    end

    // Responder A: hold-check the window, then pulse conv_done
    initial forever begin
        if (st_a !== 1'b1) begin
            @(negedge clk);
        end else begin
            h0  = a0;
            h1  = a1;
            h2  = a2;
            bad = pa.pix_ready_o;
            if (spur_start) done_a_resp = 1'b1;
            for (int i = 0; i < delay_a; i++) begin
                @(negedge clk);
                done_a_resp = 1'b0;
                if (pa.pix_ready_o !== 1'b0 || a0 !== h0 || a1 !== h1 || a2 !== h2) bad = 1'b1;
            end
            check("a_hold_no_ready", bad, 0);
            done_a_resp   = 1'b1;
            last_done_cyc = cyc;
            @(negedge clk);
            done_a_resp = 1'b0;
        end
    end

    // Monitor/responder B
    initial forever begin
        if (st_b !== 1'b1) begin
            @(negedge clk);
        end else begin
            starts_b++;
            if (qb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL b_extra_window: got start #%0d want none", starts_b);
            end else begin
                eb = qb.pop_front();
                check("b_win_top", b0, eb.i0);
                check("b_win_mid", b1, eb.i1);
                check("b_win_bot", b2, eb.i2);
            end
            repeat (2) @(negedge clk);
            done_b = 1'b1;
            @(negedge clk);
            done_b = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (fd_b === 1'b1) fds_b++;
    end

    initial begin
        int s0, f0, n;
        pa.pix_valid_i = 1'b0;
        pa.pix_i       = '0;
        pb.pix_valid_i = 1'b0;
        pb.pix_i       = '0;
        repeat (3) @(negedge clk);
        check("rst_a_img0", a0, 0);
        check("rst_a_img1", a1, 0);
        check("rst_a_img2", a2, 0);
        check("rst_a_ctl", {st_a, fd_a, busy_a, pa.pix_ready_o}, 0);
        check("rst_b_all", {b0, b1, b2, st_b, fd_b, busy_b, pb.pix_ready_o}, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("a_ready_busy_after_idle", {busy_a, pa.pix_ready_o}, 2'b11);

        delay_a = 3;
        frame_a(0, 0, 0);
        check("a_w0_img1_ch0", log1[0][39:8], 32'h04030201);
        check("a_w0_img0_zero", log0[0], 0);
        check("a_w0_img2_ch1_s1", log2[0][63:56], 8'd81);
        check("a_w3_img0_ch0", log0[3][47:0], 48'h00_24_23_22_21_00);
        check("a_w3_img2_zero", log2[3], 0);

        delay_a = 20;
        frame_a(0, 1, 0);
        check("a_f2_same_as_f1_mid", log1[5], log1[1]);

        delay_a    = 5;
        spur_start = 1'b1;
        frame_a(1, 1, 1);
        spur_start = 1'b0;

        // Partial frame, then asynchronous reset mid row 2
        delay_a = 4;
        fill_a(1);
        push_a(1);
        send_rows(2 * WA + 3, 1, 0);
        #2 rstn = 1'b0;
        #1;
        check("midrst_img0", a0, 0);
        check("midrst_img1", a1, 0);
        check("midrst_img2", a2, 0);
        check("midrst_ctl", {st_a, fd_a, busy_a, pa.pix_ready_o}, 0);
        @(negedge clk);
        rstn = 1'b1;

        delay_a = $urandom_range(1, 6);
        frame_a(1, 1, 0);

        // Smallest frame on instance B
        qb.push_back('{24'h000000, 24'h000500, 24'h000700});
        qb.push_back('{24'h000500, 24'h000700, 24'h000000});
        s0 = starts_b;
        f0 = fds_b;
        send_b(8'd5);
        send_b(8'd7);
        n = 0;
        while (fds_b == f0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        check("b_frame_done_count", fds_b - f0, 1);
        check("b_windows", starts_b - s0, 2);

        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
